// File: rtl/instruction_decode_pkg.sv
// Shared decode constants, immediate-format enum and the ID output bundle.
// Used by instruction_decode and register_file (optional macro WB_BYPASS_EN).
package instruction_decode_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_e;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic [63:0] rs1_data;
        logic [63:0] rs2_data;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7_b5;
    } id_reg_t;

    function automatic imm_fmt_e imm_format(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_IMM, OP_IMM32, OP_JALR: imm_format = IMM_I;
            OP_STORE:                           imm_format = IMM_S;
            OP_BRANCH:                          imm_format = IMM_B;
            OP_LUI, OP_AUIPC:                   imm_format = IMM_U;
            OP_JAL:                             imm_format = IMM_J;
            default:                            imm_format = IMM_NONE;
        endcase
    endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// 32 x 64-bit register file, two combinational reads, one posedge write, x0 hardwired to 0.
// WB_BYPASS_EN: a same-cycle write to the addressed register is forwarded to the read port.
module register_file
    import instruction_decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [63:0] wr_data,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [63:0] rs1_data,
    output logic [63:0] rs2_data
);

    logic [63:0] regs [32];

    // NOTE: the array is reset explicitly because every entry must read 0 after reset;
    // this costs flops rather than RAM, which is fine at 32 entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != 5'd0)) begin
            // NOTE: state is updated with <= so every read this cycle sees the pre-edge value.
            regs[wr_addr] <= wr_data;
        end
    end

    logic wr_live;
    assign wr_live = wr_en && (wr_addr != 5'd0);

`ifdef WB_BYPASS_EN
    assign rs1_data = (rs1_addr == 5'd0)                 ? 64'd0   :
                      (wr_live && (wr_addr == rs1_addr)) ? wr_data : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0)                 ? 64'd0   :
                      (wr_live && (wr_addr == rs2_addr)) ? wr_data : regs[rs2_addr];
`else
    logic unused_wr_live;
    assign unused_wr_live = wr_live;
    assign rs1_data = (rs1_addr == 5'd0) ? 64'd0 : regs[rs1_addr];
    assign rs2_data = (rs2_addr == 5'd0) ? 64'd0 : regs[rs2_addr];
`endif

endmodule

// File: rtl/instruction_decode.sv
// ID stage: field decode, immediate generation, regfile read and a 1-cycle output register.
// Write-back forwarding inside the regfile is selected by the WB_BYPASS_EN macro.
module instruction_decode
    import instruction_decode_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [63:0] pc_current,
    input  logic        if_valid,
    input  logic        stall,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [63:0] wb_data,
    output logic        id_valid,
    output logic [63:0] id_pc,
    output logic [63:0] rs1_data,
    output logic [63:0] rs2_data,
    output logic [63:0] imm,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic        funct7_b5
);

    logic [6:0]  dec_opcode;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [63:0] dec_imm;
    logic [63:0] rf_rs1_data;
    logic [63:0] rf_rs2_data;
    imm_fmt_e    fmt;
    logic        live;
    id_reg_t     id_q;
    id_reg_t     id_d;

    assign dec_opcode = instruction[6:0];
    assign dec_rd     = instruction[11:7];
    assign dec_rs1    = instruction[19:15];
    assign dec_rs2    = instruction[24:20];
    assign fmt        = imm_format(dec_opcode);

    register_file u_register_file (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wb_en),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data),
        .rs1_addr (dec_rs1),
        .rs2_addr (dec_rs2),
        .rs1_data (rf_rs1_data),
        .rs2_data (rf_rs2_data)
    );

    always_comb begin
        // NOTE: a default first keeps every path assigned, so no latch is inferred.
        dec_imm = '0;
        case (fmt)
            IMM_I: dec_imm = {{52{instruction[31]}}, instruction[31:20]};
            IMM_S: dec_imm = {{52{instruction[31]}}, instruction[31:25], instruction[11:7]};
            IMM_B: dec_imm = {{52{instruction[31]}}, instruction[7], instruction[30:25],
                              instruction[11:8], 1'b0};
            IMM_U: dec_imm = {{32{instruction[31]}}, instruction[31:12], 12'd0};
            IMM_J: dec_imm = {{44{instruction[31]}}, instruction[19:12], instruction[20],
                              instruction[30:21], 1'b0};
            default: dec_imm = '0;
        endcase
    end

    // A squashed or empty slot still loads its fields, but carries no valid bit and no rd.
    assign live = if_valid && !flush;

    always_comb begin
        id_d           = '0;
        id_d.valid     = live;
        id_d.pc        = pc_current;
        id_d.rs1_data  = rf_rs1_data;
        id_d.rs2_data  = rf_rs2_data;
        id_d.imm       = dec_imm;
        id_d.rd        = live ? dec_rd : 5'd0;
        id_d.rs1       = dec_rs1;
        id_d.rs2       = dec_rs2;
        id_d.opcode    = dec_opcode;
        id_d.funct3    = instruction[14:12];
        id_d.funct7_b5 = instruction[30];
    end

    // Flush overrides stall; stall holds everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_q <= '0;
        end else if (flush || !stall) begin
            id_q <= id_d;
        end
    end

    assign id_valid  = id_q.valid;
    assign id_pc     = id_q.pc;
    assign rs1_data  = id_q.rs1_data;
    assign rs2_data  = id_q.rs2_data;
    assign imm       = id_q.imm;
    assign rd        = id_q.rd;
    assign rs1       = id_q.rs1;
    assign rs2       = id_q.rs2;
    assign opcode    = id_q.opcode;
    assign funct3    = id_q.funct3;
    assign funct7_b5 = id_q.funct7_b5;

endmodule
